mem_data_if: RTL and testbench
==============================

# mem_data_if

Memory-stage data-bus initiator for the 5-stage MIPS core. It consumes the MEM-stage operands that the EX/MEM pipeline register presents: memory aluop, effective address, store data and exception type. For each operation it issues exactly one SRAM-like data transaction, then returns the aligned, extended load result to MEM/WB. It raises a stall request that freezes the EX/MEM and earlier stages until the transaction completes or has been drained after a flush.

## Interface
Parameters:
- none; all widths come from define.vh (`RegBus` = 32, `AluOpBus` = 8).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- mem_aluop  in  `AluOpBus`  MEM-stage op. Memory ops are EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP, plus EXE_LWL/LWR/SWL/SWR_OP when configured. All other codes are non-memory.
- mem_mem_addr  in  32  effective byte address.
- mem_reg2  in  32  store data; the merge source for LWL/LWR.
- mem_except_type  in  32  nonzero means the op is excepting; no request is issued.
- flush  in  1  pipeline flush (exception/eret).
- pipe_adv  in  1  MEM/WB enable: the current MEM op leaves the stage this edge.
- data_req  out  1  request valid.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  request address.
- data_wdata  out  32  lane-placed store data.
- data_wstrb  out  4  byte enables; 0000 for loads.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid; at most one outstanding.
- data_rdata  in  32  load response word.
- load_data  out  32  registered extended/merged load result.
- stall_req  out  1  hold EX/MEM and upstream.

## Operation
- start = memory op & mem_except_type == 0 & !flush & state IDLE.
- States:
  - IDLE: on start, drive data_req combinationally. If addr_ok, go to WAIT; else latch the request fields and go to REQ.
  - REQ: hold data_req and the latched fields. On addr_ok, go to WAIT, or to DRAIN if a flush was recorded.
  - WAIT: on data_ok, capture the result into load_data and go to DONE. On flush without data_ok, go to DRAIN. On flush with data_ok in the same cycle, go to IDLE with load_data unchanged.
  - DONE: hold load_data. On pipe_adv or flush, go to IDLE. This state prevents re-issue of the op still sitting in EX/MEM.
  - DRAIN: on data_ok, discard the response and go to IDLE.
- data_req never deasserts before addr_ok, even when flush arrives in REQ; the flush is recorded in a sticky bit that clears on leaving DRAIN.
- stall_req = (IDLE & start) | REQ | WAIT | DRAIN. It is 0 in DONE and for non-memory or excepting ops.
- Lane rules, with a = addr[1:0]:
  - Byte: wdata = {4{b}}, wstrb = 1 << a.
  - Half: wdata = {2{h}}, wstrb = 0011 << a.
  - Word: wstrb = 1111.
  - data_addr = mem_mem_addr for these ops.
- Loads select lane a (byte) or a[1] (half) from rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores complete on data_ok with load_data cleared to 0.
- Misaligned addresses never arrive without a nonzero except_type; the block does not check alignment.

## Timing
- Reset values: state IDLE, data_req 0, data_wr 0, data_size 0, data_addr 0, data_wdata 0, data_wstrb 0, load_data 0, stall_req 0, flush-sticky 0.
- Best case: req and addr_ok in cycle 0, data_ok in cycle 1. load_data is valid and stall_req = 0 in cycle 2, so the stage holds for 2 cycles.
- load_data only changes on the data_ok edge in WAIT (or on store completion).
- Reset asserted mid-transaction returns to IDLE immediately; the bus slave is reset together, so no drain is needed.

## Configuration
- UNALIGNED_LR_EN defined:
  - LWL/LWR/SWL/SWR are memory ops with data_addr = {addr[31:2], 2'b00} and size 2.
  - LWL merges rdata[8(a+1)-1:0] into the high bytes of mem_reg2.
  - LWR merges rdata[31:8a] into the low bytes of mem_reg2.
  - SWL: wstrb = 1111 >> (3-a), wdata = reg2 >> 8(3-a).
  - SWR: wstrb = 1111 << a, wdata = reg2 << 8a.
- Undefined: these four codes are non-memory ops. They issue no request, no stall, and leave load_data unchanged.

## Structure
- Package mem_if_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DONE, DRAIN);
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - the is_mem_op/is_store function over define.vh aluop codes.
- Sub-module load_align: combinational; takes aluop, a, rdata and reg2 and produces the extended/merged load word. It holds all lane and extension logic, including the LR path under the macro.

## Test plan
- LB at 0x1000_0003, rdata 0x80FF_1234, addr_ok and data_ok each one cycle after req -> size 0, wstrb 0000, load_data 0xFFFF_FF80, stall_req high exactly 2 cycles.
- SH 0xABCD1234 at 0x..02, addr_ok delayed 3 cycles -> data_req held 4 cycles with stable fields, wdata 0x12341234, wstrb 1100.
- LW with mem_except_type = 0x4 -> no data_req, stall_req 0, load_data unchanged.
- Flush in WAIT, data_ok 2 cycles later with 0xDEADBEEF -> DRAIN, stall_req high until data_ok, load_data unchanged, no new req before drain ends.
- Flush and data_ok in the same cycle in WAIT -> IDLE next cycle, no DRAIN, result discarded.
- With UNALIGNED_LR_EN: LWL a=1, rdata 0x11223344, reg2 0xAABBCCDD -> load_data 0x3344CCDD. Without the macro, the same op -> no req.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types, aluop codes and op classification for the MEM-stage data bus.
// UNALIGNED_LR_EN adds LWL/LWR/SWL/SWR to the memory-op set.
package mem_if_pkg;

  localparam int RegBus   = 32;
  localparam int AluOpBus = 8;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [AluOpBus-1:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [AluOpBus-1:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [AluOpBus-1:0] EXE_SWR_OP = 8'b1110_1110;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } mem_state_e;

  function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
      EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP,
      EXE_SH_OP, EXE_SW_OP: r = 1'b1;
`ifdef UNALIGNED_LR_EN
      EXE_LWL_OP, EXE_LWR_OP,
      EXE_SWL_OP, EXE_SWR_OP: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: r = 1'b1;
`ifdef UNALIGNED_LR_EN
      EXE_SWL_OP, EXE_SWR_OP: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] op_size(input logic [AluOpBus-1:0] op);
    logic [1:0] r;
    r = SZ_WORD;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: r = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: r = SZ_HALF;
      default: r = SZ_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_data_if_load_align.sv
// Load lane select, sign/zero extension and LWL/LWR merge.
// UNALIGNED_LR_EN enables the LWL/LWR merge paths.
module load_align
  import mem_if_pkg::*;
(
  input  logic [AluOpBus-1:0] i_aluop,
  input  logic [1:0]          i_a,
  input  logic [RegBus-1:0]   i_rdata,
  input  logic [RegBus-1:0]   i_reg2,
  output logic [RegBus-1:0]   o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_a, 3'b000} +: 8];
  assign w_half = i_rdata[{i_a[1], 4'b0000} +: 16];

`ifndef UNALIGNED_LR_EN
  logic w_unused;
  assign w_unused = ^i_reg2;
`endif

  // Pick the addressed lane and extend or merge it into a full word
  always_comb begin
    o_data = i_rdata;
    case (i_aluop)
      EXE_LB_OP:  o_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_data = {24'h0, w_byte};
      EXE_LH_OP:  o_data = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_data = {16'h0, w_half};
`ifdef UNALIGNED_LR_EN
      EXE_LWL_OP: begin
        case (i_a)
          2'd0:    o_data = {i_rdata[7:0], i_reg2[23:0]};
          2'd1:    o_data = {i_rdata[15:0], i_reg2[15:0]};
          2'd2:    o_data = {i_rdata[23:0], i_reg2[7:0]};
          default: o_data = i_rdata;
        endcase
      end
      EXE_LWR_OP: begin
        case (i_a)
          2'd0:    o_data = i_rdata;
          2'd1:    o_data = {i_reg2[31:24], i_rdata[31:8]};
          2'd2:    o_data = {i_reg2[31:16], i_rdata[31:16]};
          default: o_data = {i_reg2[31:8], i_rdata[31:24]};
        endcase
      end
`endif
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_data_if.sv
// MEM-stage SRAM-like data-bus initiator with stall and flush drain.
// UNALIGNED_LR_EN enables LWL/LWR/SWL/SWR as memory ops.
module mem_data_if
  import mem_if_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [AluOpBus-1:0] mem_aluop,
  input  logic [RegBus-1:0]   mem_mem_addr,
  input  logic [RegBus-1:0]   mem_reg2,
  input  logic [RegBus-1:0]   mem_except_type,
  input  logic                flush,
  input  logic                pipe_adv,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [RegBus-1:0]   data_addr,
  output logic [RegBus-1:0]   data_wdata,
  output logic [3:0]          data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [RegBus-1:0]   data_rdata,
  output logic [RegBus-1:0]   load_data,
  output logic                stall_req
);

  mem_state_e r_state;
  mem_state_e w_next;

  logic [AluOpBus-1:0] r_op;
  logic [RegBus-1:0]   r_addr;
  logic [RegBus-1:0]   r_reg2;
  logic                r_flush;

  logic                w_start;
  logic                w_flushed;
  logic [AluOpBus-1:0] w_op;
  logic [RegBus-1:0]   w_addr;
  logic [RegBus-1:0]   w_reg2;
  logic [1:0]          w_a;
  logic [1:0]          w_na;
  logic [RegBus-1:0]   w_baddr;
  logic [RegBus-1:0]   w_wdata;
  logic [3:0]          w_wstrb;
  logic [RegBus-1:0]   w_ld;

  assign w_start = is_mem_op(mem_aluop)
                 & (mem_except_type == '0)
                 & ~flush
                 & (r_state == S_IDLE);

  assign w_flushed = r_flush | flush;

  // In IDLE the request comes straight from EX/MEM; afterwards from the latch
  assign w_op   = (r_state == S_IDLE) ? mem_aluop    : r_op;
  assign w_addr = (r_state == S_IDLE) ? mem_mem_addr : r_addr;
  assign w_reg2 = (r_state == S_IDLE) ? mem_reg2     : r_reg2;
  assign w_a    = w_addr[1:0];
  assign w_na   = 2'd3 - w_a;

  // Lane placement of store data, byte enables and bus address
  always_comb begin
    w_baddr = w_addr;
    w_wdata = '0;
    w_wstrb = 4'b0000;
    case (w_op)
      EXE_SB_OP: begin
        w_wdata = {4{w_reg2[7:0]}};
        w_wstrb = 4'b0001 << w_a;
      end
      EXE_SH_OP: begin
        w_wdata = {2{w_reg2[15:0]}};
        w_wstrb = 4'b0011 << w_a;
      end
      EXE_SW_OP: begin
        w_wdata = w_reg2;
        w_wstrb = 4'b1111;
      end
`ifdef UNALIGNED_LR_EN
      EXE_SWL_OP: begin
        w_baddr = {w_addr[31:2], 2'b00};
        w_wdata = w_reg2 >> {w_na, 3'b000};
        w_wstrb = 4'b1111 >> w_na;
      end
      EXE_SWR_OP: begin
        w_baddr = {w_addr[31:2], 2'b00};
        w_wdata = w_reg2 << {w_a, 3'b000};
        w_wstrb = 4'b1111 << w_a;
      end
      EXE_LWL_OP, EXE_LWR_OP: begin
        w_baddr = {w_addr[31:2], 2'b00};
      end
`endif
      default: ;
    endcase
  end

  // Next-state and bus/stall outputs
  always_comb begin
    w_next     = r_state;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    data_wstrb = 4'b0000;
    stall_req  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          data_req  = 1'b1;
          stall_req = 1'b1;
          w_next = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        data_req  = 1'b1;
        stall_req = 1'b1;
        if (data_addr_ok)
          w_next = w_flushed ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (data_data_ok)
          w_next = flush ? S_IDLE : S_DONE;
        else if (flush)
          w_next = S_DRAIN;
      end
      S_DONE: begin
        if (pipe_adv | flush)
          w_next = S_IDLE;
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (data_data_ok)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (data_req) begin
      data_wr    = is_store(w_op);
      data_size  = op_size(w_op);
      data_addr  = w_baddr;
      data_wdata = w_wdata;
      data_wstrb = w_wstrb;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Capture the op fields when a transaction starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op   <= EXE_NOP_OP;
      r_addr <= '0;
      r_reg2 <= '0;
    end else if (w_start) begin
      r_op   <= mem_aluop;
      r_addr <= mem_mem_addr;
      r_reg2 <= mem_reg2;
    end
  end

  // Remember a flush that lands while the request is still unaccepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_flush <= 1'b0;
    else if (r_state == S_REQ && flush)
      r_flush <= 1'b1;
    else if (r_state == S_DRAIN && data_data_ok)
      r_flush <= 1'b0;
  end

  load_align u_align (
    .i_aluop (r_op),
    .i_a     (r_addr[1:0]),
    .i_rdata (data_rdata),
    .i_reg2  (r_reg2),
    .o_data  (w_ld)
  );

  // Result register: written only by an unflushed response in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      load_data <= '0;
    else if (r_state == S_WAIT && data_data_ok && !flush)
      load_data <= is_store(r_op) ? '0 : w_ld;
  end

endmodule

// File: tb/tb_mem_data_if.sv
// Directed bench for mem_data_if with a queue-based scoreboard.
// Build with UNALIGNED_LR_EN to exercise the LWL path.
module tb_mem_data_if;
  import mem_if_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_except_type;
  logic        flush;
  logic        pipe_adv;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] load_data;
  logic        stall_req;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  req_t        exp_req_q[$];
  logic [31:0] exp_ld_q[$];

  mem_data_if dut (
    .clk             (clk),
    .rst             (rst),
    .mem_aluop       (mem_aluop),
    .mem_mem_addr    (mem_mem_addr),
    .mem_reg2        (mem_reg2),
    .mem_except_type (mem_except_type),
    .flush           (flush),
    .pipe_adv        (pipe_adv),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_wstrb      (data_wstrb),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .load_data       (load_data),
    .stall_req       (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: bus handshakes, request hold stability, load results
  logic        pend_ld = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  logic        p_wr;
  logic [1:0]  p_size;
  req_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      pend_ld = 1'b0;
      hold = 1'b0;
    end else begin
      if (pend_ld) begin
        if (exp_ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ld_unexp act=%h exp=none", load_data);
        end else begin
          chk("load_data", load_data, exp_ld_q.pop_front());
        end
      end
      pend_ld = data_data_ok;
      if (data_req) req_cnt++;
      if (stall_req) stall_cnt++;
      if (hold) begin
        chk("hold_req", 32'(data_req), 32'd1);
        chk("hold_addr", data_addr, p_addr);
        chk("hold_wdata", data_wdata, p_wdata);
        chk("hold_wstrb", 32'(data_wstrb), 32'(p_wstrb));
        chk("hold_wr", 32'(data_wr), 32'(p_wr));
        chk("hold_size", 32'(data_size), 32'(p_size));
      end
      hold = data_req && !data_addr_ok;
      p_addr = data_addr;
      p_wdata = data_wdata;
      p_wstrb = data_wstrb;
      p_wr = data_wr;
      p_size = data_size;
      if (data_req && data_addr_ok) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexp act=%h exp=none", data_addr);
        end else begin
          e = exp_req_q.pop_front();
          chk("req_wr", 32'(data_wr), 32'(e.wr));
          chk("req_size", 32'(data_size), 32'(e.size));
          chk("req_addr", data_addr, e.addr);
          chk("req_wstrb", 32'(data_wstrb), 32'(e.wstrb));
          if (e.wr) chk("req_wdata", data_wdata, e.wdata);
        end
      end
    end
  end

  task automatic idle_in;
    mem_aluop = EXE_NOP_OP;
    mem_mem_addr = '0;
    mem_reg2 = '0;
    mem_except_type = '0;
    flush = 1'b0;
    pipe_adv = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] r2);
    mem_aluop = op;
    mem_mem_addr = a;
    mem_reg2 = r2;
  endtask

  // Best-case transaction: addr_ok with req, data_ok next cycle
  task automatic best(input string n, input logic [7:0] op,
                      input logic [31:0] a, input logic [31:0] r2,
                      input logic [31:0] rd, input req_t er,
                      input logic [31:0] eld);
    int bs, br;
    bs = stall_cnt;
    br = req_cnt;
    issue(op, a, r2);
    data_addr_ok = 1'b1;
    exp_req_q.push_back(er);
    tick;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = rd;
    exp_ld_q.push_back(eld);
    tick;
    data_data_ok = 1'b0;
    pipe_adv = 1'b1;
    @(negedge clk);
    chk({n, "_done_req"}, 32'(data_req), 32'd0);
    chk({n, "_done_stall"}, 32'(stall_req), 32'd0);
    tick;
    pipe_adv = 1'b0;
    mem_aluop = EXE_NOP_OP;
    tick;
    chk({n, "_stall_cyc"}, stall_cnt - bs, 32'd2);
    chk({n, "_req_cyc"}, req_cnt - br, 32'd1);
  endtask

  initial begin
    int bs, br;
    rst = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    tick;
    rst = 1'b1;
    tick;

    best("lb", EXE_LB_OP, 32'h1000_0003, 32'h0, 32'h80FF_1234,
         '{1'b0, SZ_BYTE, 32'h1000_0003, 32'h0, 4'b0000},
         32'hFFFF_FF80);

    // Excepting load: nothing issued, result held
    bs = stall_cnt;
    br = req_cnt;
    issue(EXE_LW_OP, 32'h1000_0000, 32'h0);
    mem_except_type = 32'h4;
    data_addr_ok = 1'b1;
    repeat (3) tick;
    idle_in();
    tick;
    chk("exc_stall", stall_cnt - bs, 32'd0);
    chk("exc_req", req_cnt - br, 32'd0);
    chk("exc_load", load_data, 32'hFFFF_FF80);

    // Store half with addr_ok delayed three cycles
    bs = stall_cnt;
    br = req_cnt;
    issue(EXE_SH_OP, 32'h1000_0002, 32'hABCD_1234);
    exp_req_q.push_back('{1'b1, SZ_HALF, 32'h1000_0002,
                          32'h1234_1234, 4'b1100});
    repeat (3) tick;
    data_addr_ok = 1'b1;
    tick;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h5555_5555;
    exp_ld_q.push_back(32'h0);
    tick;
    data_data_ok = 1'b0;
    pipe_adv = 1'b1;
    tick;
    pipe_adv = 1'b0;
    mem_aluop = EXE_NOP_OP;
    tick;
    chk("sh_stall_cyc", stall_cnt - bs, 32'd5);
    chk("sh_req_cyc", req_cnt - br, 32'd4);

    best("sb", EXE_SB_OP, 32'h1000_0001, 32'h0000_00A5, 32'h0,
         '{1'b1, SZ_BYTE, 32'h1000_0001, 32'hA5A5_A5A5, 4'b0010},
         32'h0);
    best("lbu", EXE_LBU_OP, 32'h1000_0002, 32'h0, 32'h80FF_1234,
         '{1'b0, SZ_BYTE, 32'h1000_0002, 32'h0, 4'b0000},
         32'h0000_00FF);
    best("lh", EXE_LH_OP, 32'h1000_0002, 32'h0, 32'h8001_7FFF,
         '{1'b0, SZ_HALF, 32'h1000_0002, 32'h0, 4'b0000},
         32'hFFFF_8001);
    best("lw", EXE_LW_OP, 32'h2000_0000, 32'h0, 32'hCAFE_F00D,
         '{1'b0, SZ_WORD, 32'h2000_0000, 32'h0, 4'b0000},
         32'hCAFE_F00D);

    // Flush in WAIT, response two cycles later is drained
    bs = stall_cnt;
    br = req_cnt;
    issue(EXE_LHU_OP, 32'h2000_0002, 32'h0);
    data_addr_ok = 1'b1;
    exp_req_q.push_back('{1'b0, SZ_HALF, 32'h2000_0002, 32'h0, 4'b0000});
    tick;
    data_addr_ok = 1'b0;
    flush = 1'b1;
    issue(EXE_SW_OP, 32'h2000_0010, 32'h1111_2222);
    tick;
    flush = 1'b0;
    tick;
    data_data_ok = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    exp_ld_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    chk("drain_stall", 32'(stall_req), 32'd1);
    tick;
    data_data_ok = 1'b0;
    mem_aluop = EXE_NOP_OP;
    tick;
    chk("drain_stall_cyc", stall_cnt - bs, 32'd4);
    chk("drain_req_cyc", req_cnt - br, 32'd1);

    // Flush together with data_ok in WAIT: straight back to IDLE
    bs = stall_cnt;
    br = req_cnt;
    issue(EXE_LH_OP, 32'h3000_0002, 32'h0);
    data_addr_ok = 1'b1;
    exp_req_q.push_back('{1'b0, SZ_HALF, 32'h3000_0002, 32'h0, 4'b0000});
    tick;
    data_addr_ok = 1'b0;
    flush = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'h8001_0000;
    exp_ld_q.push_back(32'hCAFE_F00D);
    tick;
    flush = 1'b0;
    data_data_ok = 1'b0;
    mem_aluop = EXE_NOP_OP;
    @(negedge clk);
    chk("fdok_stall", 32'(stall_req), 32'd0);
    tick;
    chk("fdok_stall_cyc", stall_cnt - bs, 32'd2);
    chk("fdok_req_cyc", req_cnt - br, 32'd1);

`ifdef UNALIGNED_LR_EN
    best("lwl", EXE_LWL_OP, 32'h4000_0001, 32'hAABB_CCDD, 32'h1122_3344,
         '{1'b0, SZ_WORD, 32'h4000_0000, 32'h0, 4'b0000},
         32'h3344_CCDD);
`else
    bs = stall_cnt;
    br = req_cnt;
    issue(EXE_LWL_OP, 32'h4000_0001, 32'hAABB_CCDD);
    data_addr_ok = 1'b1;
    repeat (2) tick;
    idle_in();
    tick;
    chk("lwl_off_stall", stall_cnt - bs, 32'd0);
    chk("lwl_off_req", req_cnt - br, 32'd0);
    chk("lwl_off_load", load_data, 32'hCAFE_F00D);
`endif

    // Reset in the middle of a transaction
    issue(EXE_LW_OP, 32'h5000_0000, 32'h0);
    data_addr_ok = 1'b1;
    exp_req_q.push_back('{1'b0, SZ_WORD, 32'h5000_0000, 32'h0, 4'b0000});
    tick;
    idle_in();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_stall", 32'(stall_req), 32'd0);
    chk("mrst_req", 32'(data_req), 32'd0);
    chk("mrst_load", load_data, 32'd0);
    tick;
    rst = 1'b1;
    tick;

    chk("req_q_left", exp_req_q.size(), 32'd0);
    chk("ld_q_left", exp_ld_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
